io_input_responder: RTL and testbench

- Responder end of the CPU IO read path, on the peripheral side of the memory/IO address decoder.
- Takes raw board switches and buttons and synchronises and debounces them.
- Latches button presses as sticky read-to-clear event flags.
- Returns registered 16-bit read data when the decoder raises SwitchCtrl or ButtonCtrl.

---
 rtl/io_map_pkg.sv | 24 ++
 rtl/io_debounce_bit.sv | 51 +++++
 rtl/io_input_responder.sv | 148 ++++++++++++++
 tb/tb_io_input_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: shared IO address map and read-select encoding for the
// input responder slice.
//   IO_SW_BASE   - base of the switch register region (addr[7:4]==7)
//   IO_BTN_EVT   - address of the read-to-clear button event register
//   SW_OFF_LEVEL - offset of the debounced switch levels in the switch region
//   SW_OFF_BTN   - offset of the debounced button levels in the switch region
//   IO_DW        - IO data width
package io_map_pkg;

  localparam int unsigned IO_DW        = 16;
  localparam logic [7:0]  IO_SW_BASE   = 8'h70;
  localparam logic [7:0]  IO_BTN_EVT   = 8'h80;
  localparam logic [3:0]  SW_OFF_LEVEL = 4'h0;
  localparam logic [3:0]  SW_OFF_BTN   = 4'h4;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_SW_LEVEL,
    RD_BTN_LEVEL,
    RD_BTN_EVT,
    RD_ZERO
  } rd_sel_e;

endpackage

// File: rtl/io_debounce_bit.sv
// io_debounce_bit: two-flop synchroniser plus tick-based debounce for one pin.
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high reset
//   tick   - shared debounce sample strobe (1 cycle wide)
//   pin    - raw asynchronous input
//   level  - debounced level
module io_debounce_bit #(
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic level
);

  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= pin;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (tick) begin
        // This tick is the STABLE_TICKS-th mismatching one: accept the new
        // level and clear the counter in the same cycle.
        if (r_cnt == CW'(STABLE_TICKS - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign level = r_level;

endmodule

// File: rtl/io_input_responder.sv
// io_input_responder: responder end of the CPU IO read path. Debounces board
// switches and buttons, latches button presses as sticky read-to-clear event
// flags, and returns registered 16-bit read data on SwitchCtrl/ButtonCtrl.
// Optional feature macro: IO_INPUT_IRQ_EN adds the `irq` output (OR of the
// event flags, registered).
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-high reset
//   SwitchCtrl - switch-region chip select (addr[7:4]==7 read)
//   ButtonCtrl - button event register chip select (addr==0x80 read)
//   addr_low   - register select within the switch region
//   switch_i   - raw switch pins
//   button_i   - raw button pins, active high
//   io_rdata   - registered read data, valid one cycle after the select
//   irq        - (IO_INPUT_IRQ_EN only) pending-event interrupt
module io_input_responder
  import io_map_pkg::*;
#(
  parameter int unsigned N_SW         = 16,
  parameter int unsigned N_BTN        = 5,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             SwitchCtrl,
  input  logic             ButtonCtrl,
  input  logic [3:0]       addr_low,
  input  logic [N_SW-1:0]  switch_i,
  input  logic [N_BTN-1:0] button_i,
  output logic [IO_DW-1:0] io_rdata
`ifdef IO_INPUT_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [PW-1:0]    r_presc;
  logic             w_tick;
  logic [N_SW-1:0]  w_sw_lvl;
  logic [N_BTN-1:0] w_btn_lvl;
  logic [N_BTN-1:0] r_btn_prev;
  logic [N_BTN-1:0] w_btn_rise;
  logic [N_BTN-1:0] r_evt;
  logic [IO_DW-1:0] r_rdata;
  logic [IO_DW-1:0] w_sw_ext;
  logic [IO_DW-1:0] w_btn_ext;
  logic [IO_DW-1:0] w_evt_ext;
  rd_sel_e          w_sel;

  // Prescaler: 0..TICK_DIV-1, tick on the terminal count.
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    io_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clock (clock),
      .reset (reset),
      .tick  (w_tick),
      .pin   (switch_i[i]),
      .level (w_sw_lvl[i])
    );
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    io_debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clock (clock),
      .reset (reset),
      .tick  (w_tick),
      .pin   (button_i[i]),
      .level (w_btn_lvl[i])
    );
  end

  assign w_btn_rise = w_btn_lvl & ~r_btn_prev;

  always_comb begin
    w_sel = RD_NONE;
    if (ButtonCtrl) begin
      w_sel = RD_BTN_EVT;
    end else if (SwitchCtrl) begin
      case (addr_low)
        SW_OFF_LEVEL: w_sel = RD_SW_LEVEL;
        SW_OFF_BTN:   w_sel = RD_BTN_LEVEL;
        default:      w_sel = RD_ZERO;
      endcase
    end
  end

  always_comb begin
    w_sw_ext             = '0;
    w_sw_ext[N_SW-1:0]   = w_sw_lvl;
    w_btn_ext            = '0;
    w_btn_ext[N_BTN-1:0] = w_btn_lvl;
    w_evt_ext            = '0;
    w_evt_ext[N_BTN-1:0] = r_evt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata    <= '0;
      r_evt      <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_prev <= w_btn_lvl;
      case (w_sel)
        RD_SW_LEVEL:  r_rdata <= w_sw_ext;
        RD_BTN_LEVEL: r_rdata <= w_btn_ext;
        RD_BTN_EVT:   r_rdata <= w_evt_ext;
        RD_ZERO:      r_rdata <= '0;
        default:      r_rdata <= r_rdata;
      endcase
      // A rise landing on the clearing read survives: the read returns the
      // pre-set flags and the new event stays pending.
      if (w_sel == RD_BTN_EVT) begin
        r_evt <= w_btn_rise;
      end else begin
        r_evt <= r_evt | w_btn_rise;
      end
    end
  end

  assign io_rdata = r_rdata;

`ifdef IO_INPUT_IRQ_EN
  logic r_irq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |r_evt;
    end
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_io_input_responder.sv
// tb_io_input_responder: directed self-checking bench for io_input_responder
// with TICK_DIV=4, STABLE_TICKS=3 (debounced edge 11..14 cycles after a pin
// edge). Optional irq checks follow IO_INPUT_IRQ_EN.
module tb_io_input_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        SwitchCtrl;
  logic        ButtonCtrl;
  logic [3:0]  addr_low;
  logic [15:0] switch_i;
  logic [4:0]  button_i;
  logic [15:0] io_rdata;
`ifdef IO_INPUT_IRQ_EN
  logic        irq;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int k;

  io_input_responder #(
    .N_SW         (16),
    .N_BTN        (5),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .SwitchCtrl (SwitchCtrl),
    .ButtonCtrl (ButtonCtrl),
    .addr_low   (addr_low),
    .switch_i   (switch_i),
    .button_i   (button_i),
`ifdef IO_INPUT_IRQ_EN
    .irq        (irq),
`endif
    .io_rdata   (io_rdata)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single-cycle read: selects held for exactly one sampling edge.
  task automatic rd(input logic sc, input logic bc, input logic [3:0] a);
    SwitchCtrl = sc;
    ButtonCtrl = bc;
    addr_low   = a;
    step();
    SwitchCtrl = 1'b0;
    ButtonCtrl = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; SwitchCtrl = 1'b0; ButtonCtrl = 1'b0; addr_low = 4'h0;
    switch_i = 16'hFFFF; button_i = 5'h00;
    repeat (3) step();
    rd(1'b1, 1'b0, 4'h0);
    chk("reset_rdata", io_rdata, 16'h0000);
`ifdef IO_INPUT_IRQ_EN
    chk("reset_irq", {15'h0, irq}, 16'h0000);
`endif
    reset = 1'b0;

    // Release -> levels settle at edge 12 (ticks at edges 4, 8, 12).
    repeat (2) step();
    rd(1'b1, 1'b0, 4'h0);                   // sampled at edge 3
    chk("sw_early", io_rdata, 16'h0000);
    repeat (12) step();                     // edges 4..15
    rd(1'b1, 1'b0, 4'h0);                   // sampled at edge 16
    chk("sw_settled", io_rdata, 16'hFFFF);

    // Switches low, then a 3-cycle glitch on bit 3 must be rejected.
    switch_i = 16'h0000;
    repeat (30) step();
    rd(1'b1, 1'b0, 4'h0);
    chk("sw_fall", io_rdata, 16'h0000);
    switch_i[3] = 1'b1;
    repeat (3) step();
    switch_i[3] = 1'b0;
    repeat (200) step();
    rd(1'b1, 1'b0, 4'h0);
    chk("sw_glitch", io_rdata, 16'h0000);

    // Button 2 rise: continuous level read; debounced edge L in 11..14 is
    // first visible in io_rdata at read number L+1.
    button_i[2] = 1'b1;
    SwitchCtrl = 1'b1; addr_low = 4'h4;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (io_rdata === 16'h0004) break;
    end
    SwitchCtrl = 1'b0;
    chk("btn2_level", io_rdata, 16'h0004);
    chk("btn2_latency_ok", {15'h0, (k >= 12 && k <= 15)}, 16'h0001);
    repeat (2) step();
`ifdef IO_INPUT_IRQ_EN
    chk("irq_set", {15'h0, irq}, 16'h0001);
`endif
    rd(1'b1, 1'b0, 4'h4);
    chk("lvl_no_clear", io_rdata, 16'h0004);
    rd(1'b0, 1'b1, 4'h0);
    chk("evt_read1", io_rdata, 16'h0004);
`ifdef IO_INPUT_IRQ_EN
    chk("irq_hold_on_read", {15'h0, irq}, 16'h0001);
`endif
    rd(1'b0, 1'b1, 4'h0);
    chk("evt_read2", io_rdata, 16'h0000);
`ifdef IO_INPUT_IRQ_EN
    chk("irq_drop", {15'h0, irq}, 16'h0000);
`endif
    rd(1'b1, 1'b0, 4'h4);
    chk("lvl_after_clear", io_rdata, 16'h0004);

    // Button 0 rise under a ButtonCtrl read every cycle: the read on the
    // set cycle returns 0 and the following read returns the event once.
    ButtonCtrl = 1'b1;
    button_i[0] = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (io_rdata !== 16'h0000) break;
    end
    chk("evt_collide", io_rdata, 16'h0001);
    chk("evt_collide_latency_ok", {15'h0, (k >= 13 && k <= 16)}, 16'h0001);
    step();
    ButtonCtrl = 1'b0;
    chk("evt_once", io_rdata, 16'h0000);

    // Decode corners and hold behaviour.
    rd(1'b1, 1'b0, 4'h4);
    chk("lvl_btn02", io_rdata, 16'h0005);
    rd(1'b1, 1'b0, 4'h8);
    chk("sw_unmapped", io_rdata, 16'h0000);
    rd(1'b1, 1'b0, 4'h4);
    chk("lvl_btn02_again", io_rdata, 16'h0005);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_hold", io_rdata, 16'h0005);
    end
    rd(1'b1, 1'b1, 4'h4);
    chk("btnctrl_priority", io_rdata, 16'h0000);

    // Reset mid-debounce of button 1: all progress discarded, all three
    // buttons re-debounce from scratch and appear at read 13.
    button_i[1] = 1'b1;
    repeat (7) step();
    reset = 1'b1;
    step();
    chk("midreset_rdata", io_rdata, 16'h0000);
`ifdef IO_INPUT_IRQ_EN
    chk("midreset_irq", {15'h0, irq}, 16'h0000);
`endif
    reset = 1'b0;
    SwitchCtrl = 1'b1; addr_low = 4'h4;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      k++;
      if (io_rdata === 16'h0007) break;
    end
    SwitchCtrl = 1'b0;
    chk("restart_level", io_rdata, 16'h0007);
    chk("restart_latency", 16'(k), 16'd13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
